counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 start  input  1  one-cycle request to begin a timing run; sampled in IDLE only.
REQ-004 stop  input  1  abort request; sampled in every state.
REQ-005 period  input  8  tick period P in clk cycles; 0 is illegal.
REQ-006 nrep  input  4  number of ticks per run; 0 means continuous until stop.
REQ-007 cnt_data  output  8  load value driven to the attached 8-bit loadable up-counter.
REQ-008 cnt_load  output  1  counter load strobe.
REQ-009 cnt_out  input  8  counter value, read back.
REQ-010 cnt_cout  input  1  counter carry; high while cnt_out == 8'hFF.
REQ-011 tick  output  1  one-cycle pulse per elapsed period.
REQ-012 busy  output  1  high in LOAD, CHECK and RUN.
REQ-013 done  output  1  one-cycle pulse on normal run completion.
REQ-014 err  output  1  sticky error flag.

Function
REQ-015 The attached counter loads cnt_data on a posedge with cnt_load=1; otherwise it increments modulo 256.
REQ-016 The FSM states are IDLE, LOAD, CHECK, RUN and DONE.
REQ-017 IDLE: start=1, stop=0 and period!=0 latch P=period and R=nrep, clear err, and go to LOAD.
REQ-018 IDLE: start=1 with period=0 sets err, stays in IDLE, and does not assert busy.
REQ-019 LOAD (one cycle): cnt_load=1, cnt_data=(8'd0-P) mod 256, then go to CHECK.
REQ-020 CHECK (one cycle): cnt_out must equal (0-P) mod 256; a mismatch sets err and goes to IDLE without done; a match goes to RUN.
REQ-021 CHECK with P=1: cnt_cout is already high, so CHECK handles the tick and reload exactly as RUN does (REQ-022, REQ-023).
REQ-022 RUN: tick = (state is RUN or CHECK-match) AND cnt_cout, as combinational decode of the state register and the input.
REQ-023 On each tick with R!=1 (or nrep mode 0): cnt_load=1 in the same cycle so the counter reloads instead of wrapping; R decrements unless nrep mode is 0.
REQ-024 On the tick where R==1: cnt_load=0, go to DONE.
REQ-025 Tick spacing is exactly P cycles; the first tick comes P cycles after the LOAD cycle; P=1 gives a tick every cycle.
REQ-026 DONE (one cycle): done=1, then go to IDLE.
REQ-027 stop=1 in LOAD, CHECK or RUN: go to IDLE at the next edge with cnt_load=0 that cycle; no tick, no done.
REQ-028 start is ignored while busy; stop has priority over start and over cnt_cout.
REQ-029 cnt_data holds the latched value (0-P) at all times outside reset.
REQ-030 cnt_load is 0 in IDLE and DONE.
REQ-031 err stays set until the next accepted start.

Reset
REQ-032 rst_n=0 at posedge clk forces IDLE, P=0, R=0, err=0.
REQ-033 All outputs are 0 during and after reset: cnt_data=8'h00, cnt_load=0, tick=0, busy=0, done=0, err=0.
REQ-034 A reset mid-run aborts the run with no done pulse.
REQ-035 The block does not reset the attached counter; the first LOAD reinitialises it.

Structure
REQ-036 A shared package holds the state encoding constants (3-bit: IDLE=0, LOAD=1, CHECK=2, RUN=3, DONE=4) and the width constants CNT_W=8 and REP_W=4.
REQ-037 The design is a single FSM module with no sub-modules.
REQ-038 The bench instantiates counter_ctrl connected to the existing 8-bit counter module (out, cout, data, load, clk) as the verification partner.

Verification
REQ-039 period=5, nrep=3, start pulse -> ticks 5, 10 and 15 cycles after LOAD; done 1 cycle after the third tick; busy low thereafter.
REQ-040 period=1, nrep=4 -> four ticks on consecutive cycles; cnt_data=8'hFF; then done.
REQ-041 period=8'hF0, nrep=0, stop asserted after 500 cycles -> ticks every 240 cycles; IDLE next cycle; no done.
REQ-042 period=0, start -> err=1, busy stays 0; a subsequent start with period=3 clears err.
REQ-043 rst_n=0 mid-RUN with period=10 -> all outputs 0 on the next cycle; no further ticks.
REQ-044 Counter model forced to a wrong value after LOAD -> err=1 at CHECK, return to IDLE, no tick.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
//
// Purpose : Shared definitions for the counter_ctrl timing controller.
//           - Width constants for the attached counter and the repeat count.
//           - 3-bit FSM state encoding (IDLE=0, LOAD=1, CHECK=2, RUN=3, DONE=4).
//           - Helper that turns a tick period into the counter preload value.
//
// Ports   : none (package).
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    localparam int CNT_W = 8;   // width of the attached up-counter
    localparam int REP_W = 4;   // width of the tick repeat count

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // The counter is preloaded with -P so that it reaches all-ones (carry
    // high) exactly P-1 increments after the load, i.e. P cycles after the
    // load cycle itself.
    function automatic logic [CNT_W-1:0] reload_value(input logic [CNT_W-1:0] p);
        return '0 - p;
    endfunction

endpackage

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// Purpose : Periodic tick generator built around an external 8-bit loadable
//           up-counter. A run is requested with start; the controller
//           preloads the counter with -P, verifies the load by reading the
//           counter back, then emits one tick each time the counter carry
//           rises, reloading the counter on every tick except the last.
//           After nrep ticks (or forever when nrep is 0) a one-cycle done
//           pulse is produced. stop aborts a run; a failed read-back or an
//           illegal zero period sets a sticky err flag.
//
// Ports   :
//   clk       in   1  clock, all state on the rising edge
//   rst_n     in   1  synchronous active-low reset
//   start     in   1  run request, only honoured in IDLE
//   stop      in   1  abort request, honoured in every state
//   period    in   8  tick period P in clk cycles (0 is illegal)
//   nrep      in   4  ticks per run, 0 = continuous until stop
//   cnt_data  out  8  counter load value (-P of the latched period)
//   cnt_load  out  1  counter load strobe
//   cnt_out   in   8  counter value read back
//   cnt_cout  in   1  counter carry, high while cnt_out == 8'hFF
//   tick      out  1  one-cycle pulse per elapsed period
//   busy      out  1  high in LOAD, CHECK and RUN
//   done      out  1  one-cycle pulse on normal completion
//   err       out  1  sticky error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module counter_ctrl
    import counter_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] period,
    input  logic [REP_W-1:0] nrep,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_load,
    input  logic [CNT_W-1:0] cnt_out,
    input  logic             cnt_cout,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // -------------------------------------------------------------------------
    // State and latched run parameters
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;     // latched period P
    logic [REP_W-1:0] rep_q, rep_d;     // remaining ticks R (0 = continuous)
    logic             err_q, err_d;

    // -------------------------------------------------------------------------
    // Shared decodes
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] reload;
    logic             accept;     // start taken in IDLE
    logic             reject;     // start with an illegal zero period
    logic             chk_ok;     // counter read-back matches the preload
    logic             tick_ev;    // a period has elapsed this cycle
    logic             last_tick;  // this tick completes the run

    assign reload = reload_value(per_q);

    assign accept = (state_q == ST_IDLE) && start && !stop && (period != '0);
    assign reject = (state_q == ST_IDLE) && start && !stop && (period == '0);

    assign chk_ok = (cnt_out == reload);

    // With P=1 the carry is already high during CHECK, so a matching CHECK
    // cycle is treated as a RUN cycle for tick purposes. stop wins over carry.
    assign tick_ev = !stop && cnt_cout &&
                     ((state_q == ST_RUN) || ((state_q == ST_CHECK) && chk_ok));

    // R only reaches 1 in counted mode; continuous mode keeps R at 0.
    assign last_tick = (rep_q == REP_W'(1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                state_d = stop ? ST_IDLE : ST_CHECK;
            end

            ST_CHECK: begin
                if (stop || !chk_ok) begin
                    state_d = ST_IDLE;
                end else if (tick_ev && last_tick) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick_ev && last_tick) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Run parameter and error registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_q <= '0;
            rep_q <= '0;
            err_q <= 1'b0;
        end else begin
            per_q <= per_d;
            rep_q <= rep_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        per_d = per_q;
        rep_d = rep_q;
        err_d = err_q;

        if (accept) begin
            per_d = period;
            rep_d = nrep;
            err_d = 1'b0;
        end

        if (reject) begin
            err_d = 1'b1;
        end

        // Read-back mismatch: the counter did not take the preload.
        if ((state_q == ST_CHECK) && !stop && !chk_ok) begin
            err_d = 1'b1;
        end

        // Count down intermediate ticks in counted mode only.
        if (tick_ev && !last_tick && (rep_q != '0)) begin
            rep_d = rep_q - REP_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    // Outputs are forced low while rst_n is low so that nothing leaks out in
    // the cycle in which reset is first applied.
    always_comb begin
        cnt_data = '0;
        cnt_load = 1'b0;
        tick     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;

        if (rst_n) begin
            cnt_data = reload;
            // Reload on LOAD and on every tick except the last, so the counter
            // restarts from -P instead of wrapping to 0.
            cnt_load = ((state_q == ST_LOAD) && !stop) || (tick_ev && !last_tick);
            tick     = tick_ev;
            busy     = (state_q == ST_LOAD) || (state_q == ST_CHECK) ||
                       (state_q == ST_RUN);
            done     = (state_q == ST_DONE);
            err      = err_q;
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
//
// counter_ctrl driven together with a behavioural 8-bit loadable up-counter.
// Each run's tick/done timeline is derived from the period/repeat rules
// (ticks at LOAD+k*P, done one cycle after the final tick, nothing at or after
// an abort) and queued; a monitor pops and compares whenever tick or done is
// seen. Level outputs are compared directly at chosen points.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] period = 8'd0;
    logic [3:0] nrep = 4'd0;
    logic [7:0] cnt_data;
    logic       cnt_load;
    logic [7:0] cnt_out;
    logic       cnt_cout;
    logic       tick;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Fault injection for the attached counter: mis-load when set.
    bit corrupt = 1'b0;

    typedef struct {
        int cyc;
        bit is_done;
    } ev_t;

    ev_t exp_q[$];

    counter_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .period   (period),
        .nrep     (nrep),
        .cnt_data (cnt_data),
        .cnt_load (cnt_load),
        .cnt_out  (cnt_out),
        .cnt_cout (cnt_cout),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Attached 8-bit loadable up-counter.
    logic [7:0] cnt_q = 8'd0;
    always @(posedge clk) begin
        if (cnt_load) cnt_q <= corrupt ? cnt_data + 8'd7 : cnt_data;
        else          cnt_q <= cnt_q + 8'd1;
    end
    assign cnt_out  = cnt_q;
    assign cnt_cout = (cnt_q == 8'hFF);

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every tick/done must match the head of the expected queue.
    always @(negedge clk) begin
        if (tick && done) chk("tick_done_exclusive", 1, 0);
        if (tick || done) begin
            if (exp_q.size() == 0) begin
                chk(done ? "unexpected_done" : "unexpected_tick", cyc, -1);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_kind_is_done", int'(done), int'(e.is_done));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    // Expected timeline of a run whose LOAD cycle is L. abort_c < 0 means the
    // run completes normally; otherwise nothing at or after abort_c occurs.
    task automatic push_run(input int L, input int p, input int r, input int abort_c);
        int k;
        k = 1;
        while ((r == 0 || k <= r) && (abort_c < 0 || L + k * p < abort_c)) begin
            exp_q.push_back('{L + k * p, 1'b0});
            k++;
        end
        if (r != 0 && abort_c < 0) exp_q.push_back('{L + r * p + 1, 1'b1});
    endtask

    // Pulse start for one cycle; returns the LOAD cycle. Inputs are then
    // scrambled to show the run uses the latched values.
    task automatic issue_start(input int p, input int r, output int L);
        period = 8'(p);
        nrep   = 4'(r);
        start  = 1'b1;
        step();
        start  = 1'b0;
        period = 8'($urandom_range(1, 255));
        nrep   = 4'($urandom_range(0, 15));
        L = cyc;
    endtask

    task automatic expect_drained(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic int reload_of(input int p);
        return (256 - p) % 256;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int L, c, s, p, r, end_c;
        bit abort, allow_pulse;

        // ---------------- reset state ----------------
        step(); step(); step();
        chk("rst_cnt_data", cnt_data, 0);
        chk("rst_cnt_load", cnt_load, 0);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_cnt_data", cnt_data, 0);
        chk("idle_busy", busy, 0);

        // ---------------- P=5, R=3 ----------------
        issue_start(5, 3, L);
        push_run(L, 5, 3, -1);
        chk("p5_load_busy", busy, 1);
        chk("p5_load_strobe", cnt_load, 1);
        chk("p5_cnt_data", cnt_data, reload_of(5));
        step_to(L + 17);
        chk("p5_busy_after", busy, 0);
        expect_drained("p5_pending");

        // ---------------- P=1, R=4 ----------------
        issue_start(1, 4, L);
        push_run(L, 1, 4, -1);
        step_to(L + 2);
        chk("p1_cnt_data", cnt_data, 8'hFF);
        chk("p1_reload_strobe", cnt_load, 1);
        step_to(L + 7);
        chk("p1_busy_after", busy, 0);
        expect_drained("p1_pending");

        // ---------------- P=240, continuous, stop at 500 ----------------
        issue_start(240, 0, L);
        push_run(L, 240, 0, L + 500);
        step_to(L + 500);
        stop = 1'b1;
        #1;
        chk("p240_stop_no_load", cnt_load, 0);
        step();
        stop = 1'b0;
        chk("p240_idle_after_stop", busy, 0);
        step(); step();
        expect_drained("p240_pending");

        // ---------------- period 0 is rejected ----------------
        period = 8'd0;
        nrep = 4'd2;
        start = 1'b1;
        #1;
        chk("p0_busy_same_cycle", busy, 0);
        step();
        start = 1'b0;
        chk("p0_err", err, 1);
        chk("p0_busy", busy, 0);
        step(); step();
        chk("p0_err_sticky", err, 1);
        issue_start(3, 1, L);
        push_run(L, 3, 1, -1);
        chk("p3_err_cleared", err, 0);
        chk("p3_busy", busy, 1);
        step_to(L + 6);
        expect_drained("p3_pending");

        // ---------------- reset mid-run ----------------
        issue_start(10, 0, L);
        push_run(L, 10, 0, L + 25);
        step_to(L + 25);
        rst_n = 1'b0;
        #1;
        chk("mrst_tick", tick, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_load", cnt_load, 0);
        step();
        chk("mrst_cnt_data", cnt_data, 0);
        chk("mrst_busy_next", busy, 0);
        chk("mrst_err", err, 0);
        rst_n = 1'b1;
        repeat (25) step();
        chk("mrst_busy_later", busy, 0);
        expect_drained("mrst_pending");

        // ---------------- counter read-back failure ----------------
        corrupt = 1'b1;
        issue_start(6, 2, L);
        step();
        corrupt = 1'b0;
        step();
        chk("bad_load_err", err, 1);
        chk("bad_load_busy", busy, 0);
        repeat (10) step();
        expect_drained("bad_load_pending");

        // ---------------- randomized runs ----------------
        for (int i = 0; i < 12; i++) begin
            p = $urandom_range(1, 20);
            r = $urandom_range(0, 6);
            abort = (r == 0) || ($urandom_range(0, 3) == 0);
            c = cyc;
            issue_start(p, r, L);
            s = abort ? L + $urandom_range(0, (r == 0) ? 60 : p * r) : -1;
            push_run(L, p, r, s);
            end_c = abort ? s + 1 : L + r * p + 2;
            allow_pulse = !(abort && s == L);
            while (cyc < end_c) begin
                start  = (cyc == L + 1) && allow_pulse;
                period = 8'($urandom_range(1, 255));
                stop   = abort && (cyc == s);
                if (cyc == L + 1) chk("rnd_cnt_data", cnt_data, reload_of(p));
                step();
            end
            start = 1'b0;
            stop  = 1'b0;
            chk("rnd_busy_after", busy, 0);
            chk("rnd_err", err, 0);
            step();
            chk("rnd_cnt_data_hold", cnt_data, reload_of(p));
            expect_drained("rnd_pending");
            if (c < 0) chk("rnd_cycle_order", c, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
